// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fs_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_flush.sv
// Loadable 2-bit down-counter that times the wrong-path flush window.
module flush_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (!hold_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Last flush cycle: the next non-held decrement reaches zero.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC selection, fetch enable and wrong-path flush control for IF.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        id_br_valid,
    input  logic [31:0] id_br_target,
    input  logic        if_br_valid,
    input  logic [31:0] if_br_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_out,
    output logic [31:0] im_addr,
    output logic        pc_we,
    output logic        fetch_en,
    output logic        flush_if,
    output logic        misalign_err,
    output logic [1:0]  state
);

    localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

    fs_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic        pc_upd;
    logic        cnt_load, cnt_hold, cnt_done;

    flush_counter #(.W(2)) u_flush_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (FLUSH_LD),
        .hold_i     (cnt_hold),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mis_d    = 1'b0;
        pc_upd   = 1'b0;
        cnt_load = 1'b0;
        cnt_hold = 1'b1;
        unique case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN: begin
                if (id_br_valid || if_br_valid) begin
                    pc_d     = align_pc(id_br_valid ? id_br_target : if_br_target);
                    mis_d    = id_br_valid ? |id_br_target[1:0] : |if_br_target[1:0];
                    pc_upd   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_FLUSH;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!stall_req) begin
                    pc_d   = pc_q + PC_STEP;
                    pc_upd = 1'b1;
                end
            end
            // IF-side requests here come from squashed instructions.
            ST_FLUSH: begin
                if (id_br_valid) begin
                    pc_d     = align_pc(id_br_target);
                    mis_d    = |id_br_target[1:0];
                    pc_upd   = 1'b1;
                    cnt_load = 1'b1;
                end else if (!stall_req) begin
                    pc_d     = pc_q + PC_STEP;
                    pc_upd   = 1'b1;
                    cnt_hold = 1'b0;
                    if (cnt_done) state_d = ST_RUN;
                end
            end
            ST_HALT: if (resume) state_d = ST_RUN;
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        pc_we    = 1'b0;
        fetch_en = 1'b0;
        flush_if = 1'b1;
        unique case (state_q)
            ST_RUN: begin
                pc_we    = pc_upd;
                fetch_en = pc_upd;
                flush_if = 1'b0;
            end
            ST_FLUSH: begin
                pc_we    = pc_upd;
                fetch_en = pc_upd;
            end
            default: ;
        endcase
    end

    assign pc_out       = pc_q;
    assign im_addr      = pc_q;
    assign misalign_err = mis_q;
    assign state        = state_q;

endmodule
